// File: rtl/dual_prio_pkg.sv
// Shared widths, the "no request" code and a one-hot helper for the dual priority encoder.
package dual_prio_pkg;

  localparam int unsigned REQ_W = 12;
  localparam int unsigned IDX_W = 4;

  localparam logic [IDX_W-1:0] IDX_NONE = 4'd0;

  // Index 1..REQ_W to a one-hot vector over r[REQ_W:1]; IDX_NONE gives all zeros.
  function automatic logic [REQ_W:1] idx_onehot(input logic [IDX_W-1:0] idx);
    logic [REQ_W:1] oh;
    oh = '0;
    for (int i = 1; i <= int'(REQ_W); i++) begin
      if (idx == IDX_W'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/prio_encoder_12.sv
// Combinational 12-input priority encoder: index of the highest set bit, IDX_NONE if none.
module prio_encoder_12
  import dual_prio_pkg::*;
(
  input  logic [REQ_W:1]   req,
  output logic [IDX_W-1:0] idx_c
);

  // Ascending scan so the highest set bit wins.
  always_comb begin
    idx_c = IDX_NONE;
    for (int i = 1; i <= int'(REQ_W); i++) begin
      if (req[i]) idx_c = IDX_W'(i);
    end
  end

endmodule

// File: rtl/dual_prio_encoder.sv
// Registered dual priority encoder: highest and second-highest request indices.
// Optional DUAL_PRIO_VALID_EN adds registered first_valid/second_valid flags.
module dual_prio_encoder
  import dual_prio_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic [REQ_W:1]   r,
  output logic [IDX_W-1:0] first,
  output logic [IDX_W-1:0] second
`ifdef DUAL_PRIO_VALID_EN
  ,
  output logic             first_valid,
  output logic             second_valid
`endif
);

  logic [IDX_W-1:0] first_c;
  logic [IDX_W-1:0] second_c;
  logic [REQ_W:1]   masked_c;

  prio_encoder_12 u_enc_first (
    .req   (r),
    .idx_c (first_c)
  );

  // Removing the winner leaves the runner-up as the new highest bit.
  assign masked_c = r & ~idx_onehot(first_c);

  prio_encoder_12 u_enc_second (
    .req   (masked_c),
    .idx_c (second_c)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      first  <= IDX_NONE;
      second <= IDX_NONE;
    end else begin
      first  <= first_c;
      second <= second_c;
    end
  end

`ifdef DUAL_PRIO_VALID_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      first_valid  <= 1'b0;
      second_valid <= 1'b0;
    end else begin
      first_valid  <= (first_c != IDX_NONE);
      second_valid <= (second_c != IDX_NONE);
    end
  end
`endif

endmodule

// File: tb/tb_dual_prio_encoder.sv
// Scoreboard bench for dual_prio_encoder: directed vectors, exhaustive sweep, mid-stream reset.
module tb_dual_prio_encoder;

  logic        clk;
  logic        reset_n;
  logic [12:1] r;
  logic [3:0]  first;
  logic [3:0]  second;
`ifdef DUAL_PRIO_VALID_EN
  logic        first_valid;
  logic        second_valid;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] f;
    logic [3:0] s;
    logic       fv;
    logic       sv;
    string      tag;
  } exp_t;

  exp_t exp_q[$];

  dual_prio_encoder dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .r            (r),
    .first        (first),
    .second       (second)
`ifdef DUAL_PRIO_VALID_EN
    ,
    .first_valid  (first_valid),
    .second_valid (second_valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference: scan downward, record first two set bits.
  function automatic void model(input logic [12:1] v, output logic [3:0] f, output logic [3:0] s);
    f = 4'd0;
    s = 4'd0;
    for (int i = 12; i >= 1; i--) begin
      if (v[i]) begin
        if (f == 4'd0) f = 4'(i);
        else if (s == 4'd0) s = 4'(i);
      end
    end
  endfunction

  task automatic drive(input logic rst, input logic [12:1] val,
                       input logic [3:0] f, input logic [3:0] s, input string tag);
    exp_t e;
    @(negedge clk);
    reset_n = rst;
    r       = val;
    e.f   = f;
    e.s   = s;
    e.fv  = (f != 4'd0);
    e.sv  = (s != 4'd0);
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic check4(input string tag, input string what, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s %s: got %0d, expected %0d", tag, what, got, want);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check4(e.tag, "first", first, e.f);
        check4(e.tag, "second", second, e.s);
`ifdef DUAL_PRIO_VALID_EN
        check4(e.tag, "first_valid", 4'(first_valid), 4'(e.fv));
        check4(e.tag, "second_valid", 4'(second_valid), 4'(e.sv));
`endif
        checks++;
        if ((second != 4'd0) && !(second < first)) begin
          errors++;
          $display("FAIL %s invariant second<first: first=%0d second=%0d", e.tag, first, second);
        end
        checks++;
        if ((first == 4'd0) && (second != 4'd0)) begin
          errors++;
          $display("FAIL %s invariant second=0 when first=0: second=%0d, expected 0", e.tag, second);
        end
      end
    end
  end

  initial begin
    logic [3:0] mf;
    logic [3:0] ms;
    int         wait_cycles;
    reset_n = 1'b0;
    r       = 12'h000;

    // Reset held with all requests active, then release.
    drive(1'b0, 12'hFFF, 4'd0, 4'd0, "reset_hold0");
    drive(1'b0, 12'hFFF, 4'd0, 4'd0, "reset_hold1");
    drive(1'b1, 12'hFFF, 4'd12, 4'd11, "release_fff");

    // Directed vectors, back-to-back to exercise full throughput.
    drive(1'b1, 12'h000, 4'd0,  4'd0,  "empty");
    drive(1'b1, 12'h001, 4'd1,  4'd0,  "only_r1");
    drive(1'b1, 12'h800, 4'd12, 4'd0,  "only_r12");
    drive(1'b1, 12'h801, 4'd12, 4'd1,  "pair_12_1");
    drive(1'b1, 12'h024, 4'd6,  4'd3,  "pair_6_3");
    drive(1'b1, 12'hC00, 4'd12, 4'd11, "pair_12_11");
    drive(1'b1, 12'h0A0, 4'd8,  4'd6,  "pair_8_6");
    drive(1'b1, 12'h400, 4'd11, 4'd0,  "only_r11");
    drive(1'b1, 12'h003, 4'd2,  4'd1,  "pair_2_1");
    drive(1'b1, 12'h000, 4'd0,  4'd0,  "empty_again");

    // Exhaustive sweep with a one-cycle reset pulse in the middle.
    for (int v = 0; v < 4096; v++) begin
      if (v == 2000) drive(1'b0, 12'(v), 4'd0, 4'd0, "midstream_reset");
      model(12'(v), mf, ms);
      drive(1'b1, 12'(v), mf, ms, "sweep");
    end

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
